// File: rtl/heartbeat_detector.sv
// Heart-rate front end: synchronise and debounce the pulse comparator, detect beats, measure the
// beat-to-beat interval in ms and turn it into an 8-bit BPM value with a sequential divider.
// Latency: bpm updates 18 clk after an accepted beat; batimento rises 1 clk after the filtered edge.
// No backpressure: sensor_in is sampled every clk and the outputs are plain levels.
// Optional build macro HB_AVERAGE_EN: the divisor becomes a running average of up to 4 intervals.

module heartbeat_detector #(
  parameter int TICK_DIV      = 50000,  // clk cycles per 1 ms tick
  parameter int DEBOUNCE_MS   = 20,     // stable time before the filtered level follows
  parameter int REFRACTORY_MS = 250,    // shortest accepted beat interval
  parameter int TIMEOUT_MS    = 3000,   // interval at which the pulse is declared lost
  parameter int BEAT_HOLD_MS  = 50      // batimento high time per accepted beat
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_in,
  output logic       batimento,
  output logic [7:0] bpm,
  output logic       bpm_valid,
  output logic       no_pulse
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int HW = $clog2(BEAT_HOLD_MS + 1);

  localparam logic [PW-1:0] C_TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] C_DB_LAST   = DW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] C_HOLD      = HW'(BEAT_HOLD_MS);
  localparam logic [15:0]   C_REFR      = 16'(REFRACTORY_MS);
  localparam logic [15:0]   C_TIMEOUT   = 16'(TIMEOUT_MS);
  localparam logic [16:0]   C_DIVIDEND  = 17'd60000;  // ms per minute
  localparam logic [4:0]    C_STEPS_BPM = 5'd17;      // one quotient bit per clk over 17 bits

  typedef enum logic [1:0] {
    S_WAIT_FIRST = 2'd0,
    S_TRACK      = 2'd1,
    S_DIVIDE     = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------------------------
  logic          r_sync1, r_sync2;
  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic [DW-1:0] r_db_cnt;
  logic          r_filt, r_filt_d;
  logic          w_beat;
  logic [15:0]   r_interval;
  logic [HW-1:0] r_hold;

  state_t        r_state, w_state_nxt;
  logic          w_refr_ok, w_at_timeout, w_div_last;
  logic          w_first, w_accept, w_timeout, w_div_done;

  logic [15:0]   r_rem;       // partial remainder, always below the divisor
  logic [17:0]   r_quo;       // dividend bits shift out of the top, quotient bits in at the bottom
  logic [15:0]   r_dvs;
  logic [4:0]    r_steps;     // quotient bits still to produce
  logic [16:0]   w_rem_sh;
  logic [15:0]   w_rem_sub;
  logic          w_ge;
  logic [16:0]   w_quo_res;

  logic [17:0]   w_ld_quo;
  logic [15:0]   w_ld_dvs;
  logic [4:0]    w_ld_steps;

  logic [7:0]    r_bpm;
  logic          r_bpm_valid;
  logic          r_no_pulse;

  // ---------------------------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------------------------

  // two-flop synchroniser for the comparator output, which is asynchronous to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sensor_in;
      r_sync2 <= r_sync1;
    end
  end

  // 1 ms prescaler: counts 0..TICK_DIV-1 and the wrap cycle is the tick
  assign w_tick = (r_presc == C_TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // debounce: the filtered level flips only after DEBOUNCE_MS ticks of a differing level;
  // any return to the filtered level restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt <= '0;
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
    end else begin
      r_filt_d <= r_filt;
      if (r_sync2 == r_filt) begin
        r_db_cnt <= '0;
      end else if (w_tick) begin
        if (r_db_cnt == C_DB_LAST) begin
          r_filt   <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end
    end
  end

  // a beat is the one-clk rising edge of the filtered level
  assign w_beat = r_filt & ~r_filt_d;

  // ---------------------------------------------------------------------------------------------
  // Interval measurement and beat strobe
  // ---------------------------------------------------------------------------------------------

  // interval in ms since the last accepted beat, saturating at the timeout value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_interval <= '0;
    end else if (w_first || w_accept) begin
      r_interval <= '0;
    end else if (w_tick && (r_interval < C_TIMEOUT)) begin
      r_interval <= r_interval + 1'b1;
    end
  end

  // batimento hold counter: reloads on every accepted beat, a timeout does not cut it short
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (w_first || w_accept) begin
      r_hold <= C_HOLD;
    end else if (w_tick && (r_hold != '0)) begin
      r_hold <= r_hold - 1'b1;
    end
  end

  assign w_refr_ok    = (r_interval >= C_REFR);
  assign w_at_timeout = (r_interval >= C_TIMEOUT);

  // ---------------------------------------------------------------------------------------------
  // Beat tracking FSM
  // ---------------------------------------------------------------------------------------------

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_WAIT_FIRST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic; an accepted beat takes priority over a timeout in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_FIRST: begin
        if (w_beat) w_state_nxt = S_TRACK;
      end
      S_TRACK: begin
        if (w_beat && w_refr_ok) begin
          w_state_nxt = S_DIVIDE;
        end else if (w_at_timeout) begin
          w_state_nxt = S_WAIT_FIRST;
        end
      end
      S_DIVIDE: begin
        if (w_div_last) w_state_nxt = S_TRACK;
      end
      default: w_state_nxt = S_WAIT_FIRST;
    endcase
  end

  // FSM strobes driving the datapath; beats seen during DIVIDE are dropped
  always_comb begin
    w_first    = 1'b0;
    w_accept   = 1'b0;
    w_timeout  = 1'b0;
    w_div_done = 1'b0;
    case (r_state)
      S_WAIT_FIRST: begin
        w_first = w_beat;
      end
      S_TRACK: begin
        w_accept  = w_beat && w_refr_ok;
        w_timeout = !(w_beat && w_refr_ok) && w_at_timeout;
      end
      S_DIVIDE: begin
        w_div_done = w_div_last;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Divisor selection
  // ---------------------------------------------------------------------------------------------
`ifdef HB_AVERAGE_EN
  // The three previous accepted intervals; together with the interval being latched they form
  // the 4-entry average window.
  logic [15:0] r_hist [0:2];
  logic [1:0]  r_hcnt;        // valid entries in r_hist
  logic [17:0] w_sum;
  logic        r_phase;       // 1 while the divider is producing sum / 3
  logic        w_ld_phase;

  // sum of the new interval and the history entries filled so far
  always_comb begin
    w_sum = {2'b00, r_interval};
    if (r_hcnt >= 2'd1) w_sum = w_sum + {2'b00, r_hist[0]};
    if (r_hcnt >= 2'd2) w_sum = w_sum + {2'b00, r_hist[1]};
    if (r_hcnt == 2'd3) w_sum = w_sum + {2'b00, r_hist[2]};
  end

  // interval history, cleared whenever the pulse train is lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist[0] <= '0;
      r_hist[1] <= '0;
      r_hist[2] <= '0;
      r_hcnt    <= '0;
    end else if (w_timeout) begin
      r_hist[0] <= '0;
      r_hist[1] <= '0;
      r_hist[2] <= '0;
      r_hcnt    <= '0;
    end else if (w_accept) begin
      r_hist[0] <= r_interval;
      r_hist[1] <= r_hist[0];
      r_hist[2] <= r_hist[1];
      if (r_hcnt != 2'd3) r_hcnt <= r_hcnt + 1'b1;
    end
  end

  // divider load values: powers of two are shifts, three entries need a pre-division by 3
  always_comb begin
    w_ld_quo   = {C_DIVIDEND, 1'b0};
    w_ld_dvs   = r_interval;
    w_ld_steps = C_STEPS_BPM;
    w_ld_phase = 1'b0;
    case (r_hcnt)
      2'd1: w_ld_dvs = w_sum[16:1];
      2'd2: begin
        w_ld_quo   = w_sum;
        w_ld_dvs   = 16'd3;
        w_ld_steps = 5'd18;
        w_ld_phase = 1'b1;
      end
      2'd3: w_ld_dvs = w_sum[17:2];
      default: ;
    endcase
  end

  assign w_div_last = (r_steps == 5'd0) && !r_phase;
`else
  // divisor is the latest interval; the 17-bit dividend sits left-aligned in the 18-bit register
  always_comb begin
    w_ld_quo   = {C_DIVIDEND, 1'b0};
    w_ld_dvs   = r_interval;
    w_ld_steps = C_STEPS_BPM;
  end

  assign w_div_last = (r_steps == 5'd0);
`endif

  // ---------------------------------------------------------------------------------------------
  // Restoring divider: one quotient bit per clk, plus a final write-back cycle
  // ---------------------------------------------------------------------------------------------
  assign w_rem_sh  = {r_rem, r_quo[17]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_sub = w_rem_sh[15:0] - r_dvs;   // exact whenever w_ge, result is below r_dvs
  assign w_quo_res = r_quo[16:0];

  // divider datapath; a reset mid-division simply drops the partial result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_steps <= '0;
`ifdef HB_AVERAGE_EN
      r_phase <= 1'b0;
`endif
    end else if (w_accept) begin
      r_rem   <= '0;
      r_quo   <= w_ld_quo;
      r_dvs   <= w_ld_dvs;
      r_steps <= w_ld_steps;
`ifdef HB_AVERAGE_EN
      r_phase <= w_ld_phase;
`endif
    end else if (r_state == S_DIVIDE) begin
      if (r_steps != 5'd0) begin
        r_rem   <= w_ge ? w_rem_sub : w_rem_sh[15:0];
        r_quo   <= {r_quo[16:0], w_ge};
        r_steps <= r_steps - 1'b1;
      end
`ifdef HB_AVERAGE_EN
      else if (r_phase) begin
        // sum / 3 becomes the divisor of the BPM division
        r_rem   <= '0;
        r_dvs   <= r_quo[15:0];
        r_quo   <= {C_DIVIDEND, 1'b0};
        r_steps <= C_STEPS_BPM;
        r_phase <= 1'b0;
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------------------------

  // bpm / status: cleared on timeout, saturating update when the division completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bpm       <= '0;
      r_bpm_valid <= 1'b0;
      r_no_pulse  <= 1'b1;
    end else begin
      if (w_timeout) begin
        r_bpm       <= '0;
        r_bpm_valid <= 1'b0;
        r_no_pulse  <= 1'b1;
      end else if (w_first) begin
        r_no_pulse  <= 1'b0;
      end else if (w_div_done) begin
        r_bpm       <= (|w_quo_res[16:8]) ? 8'hFF : w_quo_res[7:0];
        r_bpm_valid <= 1'b1;
      end
    end
  end

  assign batimento = (r_hold != '0);
  assign bpm       = r_bpm;
  assign bpm_valid = r_bpm_valid;
  assign no_pulse  = r_no_pulse;

endmodule
